// File: rtl/icache_refill_axi.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_axi
//  Description : AXI read-burst engine for instruction-cache line fills.
//                Takes a level-held miss request from the I$, issues one INCR
//                burst covering the whole line on AR, and streams the R beats
//                back to the cache one cycle later with valid/last strobes.
//  Ports       : clk, rst (async, active-high)
//                I$ side  : inst_addr_mmu, inst_read_req -> inst_addr_ok,
//                           inst_read_data, inst_mmu_valid, inst_mmu_last
//                AXI AR   : arid, araddr, arlen, arsize, arburst, arlock,
//                           arcache, arprot, arvalid, arready
//                AXI R    : rid, rdata, rresp, rlast, rvalid, rready
//  Options     : define ICACHE_REFILL_ERR_EN to add the sticky refill_err
//                output (bad rresp or rlast disagreeing with the beat count).
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_axi #(
    parameter int unsigned LINE_WORDS = 8,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr_mmu,
    input  logic        inst_read_req,
    output logic        inst_addr_ok,
    output logic [31:0] inst_read_data,
    output logic        inst_mmu_valid,
    output logic        inst_mmu_last,
`ifdef ICACHE_REFILL_ERR_EN
    output logic        refill_err,
`endif
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int unsigned c_CNT_W = $clog2(LINE_WORDS);
    localparam int unsigned c_OFF_W = 2 + c_CNT_W;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(LINE_WORDS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_beat_cnt;
    logic [31:0]        r_araddr;
    logic [31:0]        r_rdata;
    logic               r_addr_ok;
    logic               r_valid;
    logic               r_last;
    logic               w_req_acc;
    logic               w_ar_hs;
    logic               w_beat_acc;
    logic               w_final_beat;

    assign w_req_acc    = (r_state == c_IDLE) && inst_read_req;
    assign w_ar_hs      = (r_state == c_ADDR) && arready;
    // Beats tagged with a foreign id are acknowledged on the bus but never
    // counted into the line.
    assign w_beat_acc   = (r_state == c_DATA) && rvalid && (rid == AXI_ID);
    // The beat counter alone ends the line; rlast is not trusted for it.
    assign w_final_beat = w_beat_acc && (r_beat_cnt == c_LAST_BEAT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded handshake strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        arvalid     = 1'b0;
        rready      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_req_acc) w_state_nxt = c_ADDR;
            end
            c_ADDR: begin
                arvalid = 1'b1;
                if (w_ar_hs) w_state_nxt = c_DATA;
            end
            c_DATA: begin
                rready = 1'b1;
                if (w_final_beat) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address latch, beat counter, registered cache-side outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_araddr   <= '0;
            r_beat_cnt <= '0;
            r_rdata    <= '0;
            r_addr_ok  <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_addr_ok <= w_ar_hs;
            r_valid   <= w_beat_acc;
            r_last    <= w_final_beat;
            // Address is captured only in IDLE, so later changes on the
            // miss port cannot disturb an AR already presented.
            if (w_req_acc) begin
                r_araddr <= {inst_addr_mmu[31:c_OFF_W], {c_OFF_W{1'b0}}};
            end
            if (w_ar_hs) begin
                r_beat_cnt <= '0;
            end else if (w_beat_acc) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (w_beat_acc) begin
                r_rdata <= rdata;
            end
        end
    end

    assign inst_addr_ok   = r_addr_ok;
    assign inst_read_data = r_rdata;
    assign inst_mmu_valid = r_valid;
    assign inst_mmu_last  = r_last;

    assign arid    = AXI_ID;
    assign araddr  = r_araddr;
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

`ifdef ICACHE_REFILL_ERR_EN
    logic r_err;
    logic w_err_beat;
    logic w_unused;

    assign w_err_beat = w_beat_acc &&
                        ((rresp != 2'b00) || (rlast != (r_beat_cnt == c_LAST_BEAT)));

    // Sticky across the line; only a freshly accepted request clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_req_acc) begin
            r_err <= 1'b0;
        end else if (w_err_beat) begin
            r_err <= 1'b1;
        end
    end

    assign refill_err = r_err;
    assign w_unused   = ^inst_addr_mmu[c_OFF_W-1:0];
`else
    logic w_unused;
    assign w_unused = ^{inst_addr_mmu[c_OFF_W-1:0], rresp, rlast};
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_axi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_refill_axi
//  Description : Directed self-checking bench for icache_refill_axi
//                (LINE_WORDS=8). Exercises ICACHE_REFILL_ERR_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_axi;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr_mmu;
    logic        inst_read_req;
    logic        inst_addr_ok;
    logic [31:0] inst_read_data;
    logic        inst_mmu_valid;
    logic        inst_mmu_last;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
`ifdef ICACHE_REFILL_ERR_EN
    logic        refill_err;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    icache_refill_axi #(
        .LINE_WORDS (8),
        .AXI_ID     (4'd0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_addr_mmu  (inst_addr_mmu),
        .inst_read_req  (inst_read_req),
        .inst_addr_ok   (inst_addr_ok),
        .inst_read_data (inst_read_data),
        .inst_mmu_valid (inst_mmu_valid),
        .inst_mmu_last  (inst_mmu_last),
`ifdef ICACHE_REFILL_ERR_EN
        .refill_err     (refill_err),
`endif
        .arid           (arid),
        .araddr         (araddr),
        .arlen          (arlen),
        .arsize         (arsize),
        .arburst        (arburst),
        .arlock         (arlock),
        .arcache        (arcache),
        .arprot         (arprot),
        .arvalid        (arvalid),
        .arready        (arready),
        .rid            (rid),
        .rdata          (rdata),
        .rresp          (rresp),
        .rlast          (rlast),
        .rvalid         (rvalid),
        .rready         (rready)
    );

    // Passive monitor, sampled on the falling edge.
    logic [31:0] cap_data [0:255];
    logic        cap_last [0:255];
    int          cap_n      = 0;
    int          ok_n       = 0;
    int          hs_n       = 0;
    int          last_n     = 0;
    int          unstable_n = 0;
    logic        pend       = 1'b0;
    logic [31:0] pend_addr  = '0;

    always @(negedge clk) begin
        if (inst_mmu_valid) begin
            cap_data[cap_n[7:0]] <= inst_read_data;
            cap_last[cap_n[7:0]] <= inst_mmu_last;
            cap_n <= cap_n + 1;
        end
        if (inst_mmu_last) last_n <= last_n + 1;
        if (inst_addr_ok) ok_n <= ok_n + 1;
        if (arvalid && arready) hs_n <= hs_n + 1;
        if (pend && !rst && (!arvalid || araddr != pend_addr)) unstable_n <= unstable_n + 1;
        pend      <= arvalid && !arready;
        pend_addr <= araddr;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive n id-matching beats (data seed+k); optional foreign-id beat
    // before good beat bad_pos, rresp=SLVERR on err_pos, rlast on rlast_pos.
    task automatic beats(input logic [31:0] seed, input int n, input int gap,
                         input int bad_pos, input int err_pos, input int rlast_pos);
        int k = 0;
        bit bad_done = 1'b0;
        while (k < n) begin
            rvalid = 1'b1;
            if (k == bad_pos && !bad_done) begin
                rid = 4'd3; rdata = 32'hDEAD_BEEF; rresp = 2'b00; rlast = 1'b0;
                bad_done = 1'b1;
            end else begin
                rid   = 4'd0;
                rdata = seed + 32'(k);
                rresp = (k == err_pos) ? 2'b10 : 2'b00;
                rlast = (k == rlast_pos);
                k = k + 1;
            end
            step;
            rvalid = 1'b0;
            for (int g = 0; g < gap; g++) step;
        end
        rid = 4'd0; rresp = 2'b00; rlast = 1'b0;
    endtask

    task automatic test_reset;
        n_total++; if (arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b want 0", arvalid); else n_pass++;
        n_total++; if (rready !== 1'b0) $display("FAIL rst_rready: got %b want 0", rready); else n_pass++;
        n_total++; if (inst_addr_ok !== 1'b0) $display("FAIL rst_addr_ok: got %b want 0", inst_addr_ok); else n_pass++;
        n_total++; if (inst_mmu_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", inst_mmu_valid); else n_pass++;
        n_total++; if (inst_mmu_last !== 1'b0) $display("FAIL rst_last: got %b want 0", inst_mmu_last); else n_pass++;
        n_total++; if (inst_read_data !== 32'h0) $display("FAIL rst_data: got %h want 0", inst_read_data); else n_pass++;
        n_total++; if (araddr !== 32'h0) $display("FAIL rst_araddr: got %h want 0", araddr); else n_pass++;
        n_total++; if (arid !== 4'd0) $display("FAIL const_arid: got %h want 0", arid); else n_pass++;
        n_total++; if (arsize !== 3'b010) $display("FAIL const_arsize: got %b want 010", arsize); else n_pass++;
        n_total++; if ({arlock, arcache, arprot} !== 9'd0) $display("FAIL const_misc: got %h want 0", {arlock, arcache, arprot}); else n_pass++;
`ifdef ICACHE_REFILL_ERR_EN
        n_total++; if (refill_err !== 1'b0) $display("FAIL rst_err: got %b want 0", refill_err); else n_pass++;
`endif
    endtask

    task automatic test_basic;
        int c0 = cap_n; int o0 = ok_n; int h0 = hs_n; int l0 = last_n;
        arready = 1'b1; inst_addr_mmu = 32'h0000_1234; inst_read_req = 1'b1;
        step;
        n_total++; if (arvalid !== 1'b1) $display("FAIL basic_arvalid: got %b want 1", arvalid); else n_pass++;
        n_total++; if (araddr !== 32'h0000_1220) $display("FAIL basic_araddr: got %h want 00001220", araddr); else n_pass++;
        n_total++; if (arlen !== 8'd7) $display("FAIL basic_arlen: got %0d want 7", arlen); else n_pass++;
        n_total++; if (arburst !== 2'b01) $display("FAIL basic_arburst: got %b want 01", arburst); else n_pass++;
        n_total++; if (inst_addr_ok !== 1'b0) $display("FAIL basic_ok_early: got %b want 0", inst_addr_ok); else n_pass++;
        step;
        n_total++; if (inst_addr_ok !== 1'b1) $display("FAIL basic_ok: got %b want 1", inst_addr_ok); else n_pass++;
        n_total++; if (arvalid !== 1'b0) $display("FAIL basic_ar_drop: got %b want 0", arvalid); else n_pass++;
        n_total++; if (rready !== 1'b1) $display("FAIL basic_rready: got %b want 1", rready); else n_pass++;
        inst_read_req = 1'b0; inst_addr_mmu = 32'hFFFF_FFFF;
        step;
        n_total++; if (inst_addr_ok !== 1'b0) $display("FAIL basic_ok_pulse: got %b want 0", inst_addr_ok); else n_pass++;
        beats(32'h1000_0000, 8, 0, -1, -1, 7);
        n_total++; if (rready !== 1'b0) $display("FAIL basic_rready_end: got %b want 0", rready); else n_pass++;
        n_total++; if (inst_read_data !== 32'h1000_0007) $display("FAIL basic_lastdata: got %h want 10000007", inst_read_data); else n_pass++;
        step; step;
        n_total++; if (cap_n - c0 !== 8) $display("FAIL basic_count: got %0d want 8", cap_n - c0); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++; if (cap_data[c0 + i] !== 32'h1000_0000 + 32'(i)) $display("FAIL basic_data%0d: got %h want %h", i, cap_data[c0 + i], 32'h1000_0000 + 32'(i)); else n_pass++;
            n_total++; if (cap_last[c0 + i] !== (i == 7)) $display("FAIL basic_last%0d: got %b want %b", i, cap_last[c0 + i], (i == 7)); else n_pass++;
        end
        n_total++; if (last_n - l0 !== 1) $display("FAIL basic_last_cnt: got %0d want 1", last_n - l0); else n_pass++;
        n_total++; if (ok_n - o0 !== 1) $display("FAIL basic_ok_cnt: got %0d want 1", ok_n - o0); else n_pass++;
        n_total++; if (hs_n - h0 !== 1) $display("FAIL basic_hs_cnt: got %0d want 1", hs_n - h0); else n_pass++;
    endtask

    task automatic test_ar_wait;
        int c0 = cap_n; int o0 = ok_n; int u0 = unstable_n;
        arready = 1'b0; inst_addr_mmu = 32'h0000_4ABC; inst_read_req = 1'b1;
        step;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (arvalid !== 1'b1 || araddr !== 32'h0000_4AA0 || inst_addr_ok !== 1'b0)
                $display("FAIL arwait_hold%0d: got v=%b a=%h ok=%b want v=1 a=00004aa0 ok=0", i, arvalid, araddr, inst_addr_ok);
            else n_pass++;
            inst_addr_mmu = 32'hFFFF_FFE0;
            step;
        end
        arready = 1'b1;
        step;
        n_total++; if (inst_addr_ok !== 1'b1) $display("FAIL arwait_ok: got %b want 1", inst_addr_ok); else n_pass++;
        inst_read_req = 1'b0;
        beats(32'h2000_0000, 8, 0, -1, -1, 7);
        step; step;
        n_total++; if (ok_n - o0 !== 1) $display("FAIL arwait_ok_cnt: got %0d want 1", ok_n - o0); else n_pass++;
        n_total++; if (unstable_n - u0 !== 0) $display("FAIL arwait_stable: got %0d want 0", unstable_n - u0); else n_pass++;
        n_total++; if (cap_n - c0 !== 8) $display("FAIL arwait_count: got %0d want 8", cap_n - c0); else n_pass++;
        n_total++; if (cap_data[c0 + 7] !== 32'h2000_0007 || cap_last[c0 + 7] !== 1'b1) $display("FAIL arwait_end: got %h/%b want 20000007/1", cap_data[c0 + 7], cap_last[c0 + 7]); else n_pass++;
    endtask

    task automatic test_gapped_rid;
        int c0 = cap_n; int l0 = last_n;
        arready = 1'b1; inst_addr_mmu = 32'h0000_2004; inst_read_req = 1'b1;
        step;
        n_total++; if (araddr !== 32'h0000_2000) $display("FAIL gap_araddr: got %h want 00002000", araddr); else n_pass++;
        step;
        inst_read_req = 1'b0;
        beats(32'h3000_0000, 8, 2, 3, -1, 7);
        step; step;
        n_total++; if (cap_n - c0 !== 8) $display("FAIL gap_count: got %0d want 8", cap_n - c0); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++; if (cap_data[c0 + i] !== 32'h3000_0000 + 32'(i)) $display("FAIL gap_data%0d: got %h want %h", i, cap_data[c0 + i], 32'h3000_0000 + 32'(i)); else n_pass++;
        end
        n_total++; if (last_n - l0 !== 1 || cap_last[c0 + 7] !== 1'b1) $display("FAIL gap_last: got cnt=%0d flag=%b want 1/1", last_n - l0, cap_last[c0 + 7]); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int c0;
        arready = 1'b1; inst_addr_mmu = 32'h0000_3000; inst_read_req = 1'b1;
        step; step;
        inst_read_req = 1'b0;
        beats(32'h4000_0000, 4, 0, -1, -1, -1);
        n_total++; if (inst_mmu_valid !== 1'b1 || inst_read_data !== 32'h4000_0003) $display("FAIL rmid_beat4: got %b/%h want 1/40000003", inst_mmu_valid, inst_read_data); else n_pass++;
        rid = 4'd0; rdata = 32'h5555_5555; rvalid = 1'b1;
        rst = 1'b1;
        #1;
        n_total++; if ({inst_mmu_valid, inst_mmu_last, inst_addr_ok, arvalid, rready} !== 5'b0) $display("FAIL rmid_strobes: got %b want 00000", {inst_mmu_valid, inst_mmu_last, inst_addr_ok, arvalid, rready}); else n_pass++;
        n_total++; if (inst_read_data !== 32'h0 || araddr !== 32'h0) $display("FAIL rmid_regs: got %h/%h want 0/0", inst_read_data, araddr); else n_pass++;
        step; step;
        rst = 1'b0;
        step;
        n_total++; if (inst_mmu_valid !== 1'b0 || rready !== 1'b0) $display("FAIL rmid_drop: got v=%b rr=%b want 0/0", inst_mmu_valid, rready); else n_pass++;
        rvalid = 1'b0;
        c0 = cap_n;
        inst_addr_mmu = 32'h0000_0080; inst_read_req = 1'b1;
        step;
        n_total++; if (arvalid !== 1'b1 || araddr !== 32'h0000_0080) $display("FAIL rmid_ar: got %b/%h want 1/00000080", arvalid, araddr); else n_pass++;
        step;
        inst_read_req = 1'b0;
        beats(32'h6000_0000, 8, 0, -1, -1, 7);
        step; step;
        n_total++; if (cap_n - c0 !== 8) $display("FAIL rmid_count: got %0d want 8", cap_n - c0); else n_pass++;
        n_total++; if (cap_data[c0] !== 32'h6000_0000) $display("FAIL rmid_first: got %h want 60000000", cap_data[c0]); else n_pass++;
        n_total++; if (cap_data[c0 + 7] !== 32'h6000_0007 || cap_last[c0 + 7] !== 1'b1 || cap_last[c0 + 6] !== 1'b0) $display("FAIL rmid_last: got %h/%b/%b want 60000007/1/0", cap_data[c0 + 7], cap_last[c0 + 7], cap_last[c0 + 6]); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int c0 = cap_n; int h0;
        arready = 1'b1; inst_addr_mmu = 32'h0000_5000; inst_read_req = 1'b1;
        step; step;
        inst_read_req = 1'b0;
        h0 = hs_n;
        beats(32'h7000_0000, 4, 0, -1, -1, -1);
        inst_read_req = 1'b1; inst_addr_mmu = 32'h0000_6008;
        step;
        n_total++; if (arvalid !== 1'b0) $display("FAIL b2b_no_ar_data: got %b want 0", arvalid); else n_pass++;
        inst_read_req = 1'b0;
        step;
        inst_read_req = 1'b1;
        beats(32'h7000_0004, 4, 0, -1, -1, 3);
        n_total++; if (arvalid !== 1'b0) $display("FAIL b2b_idle_gap: got %b want 0", arvalid); else n_pass++;
        n_total++; if (hs_n - h0 !== 0) $display("FAIL b2b_no_hs: got %0d want 0", hs_n - h0); else n_pass++;
        step;
        n_total++; if (arvalid !== 1'b1 || araddr !== 32'h0000_6000) $display("FAIL b2b_ar: got %b/%h want 1/00006000", arvalid, araddr); else n_pass++;
        step;
        n_total++; if (inst_addr_ok !== 1'b1) $display("FAIL b2b_ok: got %b want 1", inst_addr_ok); else n_pass++;
        inst_read_req = 1'b0;
        beats(32'h8000_0000, 8, 0, -1, -1, 7);
        step; step;
        n_total++; if (cap_n - c0 !== 16) $display("FAIL b2b_count: got %0d want 16", cap_n - c0); else n_pass++;
        n_total++; if (cap_data[c0 + 7] !== 32'h7000_0007 || cap_last[c0 + 7] !== 1'b1) $display("FAIL b2b_line1: got %h/%b want 70000007/1", cap_data[c0 + 7], cap_last[c0 + 7]); else n_pass++;
        n_total++; if (cap_data[c0 + 15] !== 32'h8000_0007 || cap_last[c0 + 15] !== 1'b1) $display("FAIL b2b_line2: got %h/%b want 80000007/1", cap_data[c0 + 15], cap_last[c0 + 15]); else n_pass++;
    endtask

`ifdef ICACHE_REFILL_ERR_EN
    task automatic test_err;
        arready = 1'b1; inst_addr_mmu = 32'h0000_9000; inst_read_req = 1'b1;
        step; step;
        inst_read_req = 1'b0;
        n_total++; if (refill_err !== 1'b0) $display("FAIL err_start: got %b want 0", refill_err); else n_pass++;
        beats(32'hA000_0000, 2, 0, -1, -1, -1);
        n_total++; if (refill_err !== 1'b0) $display("FAIL err_pre: got %b want 0", refill_err); else n_pass++;
        beats(32'hA000_0002, 1, 0, -1, 0, -1);
        n_total++; if (refill_err !== 1'b1) $display("FAIL err_set: got %b want 1", refill_err); else n_pass++;
        beats(32'hA000_0003, 5, 0, -1, -1, 4);
        n_total++; if (refill_err !== 1'b1 || inst_mmu_last !== 1'b1) $display("FAIL err_hold_end: got %b/%b want 1/1", refill_err, inst_mmu_last); else n_pass++;
        step; step;
        n_total++; if (refill_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", refill_err); else n_pass++;
        inst_addr_mmu = 32'h0000_A000; inst_read_req = 1'b1;
        step;
        n_total++; if (refill_err !== 1'b0) $display("FAIL err_clear: got %b want 0", refill_err); else n_pass++;
        step;
        inst_read_req = 1'b0;
        beats(32'hB000_0000, 8, 0, -1, -1, 7);
        n_total++; if (refill_err !== 1'b0) $display("FAIL err_clean: got %b want 0", refill_err); else n_pass++;
        step;
        inst_read_req = 1'b1;
        step; step;
        inst_read_req = 1'b0;
        beats(32'hC000_0000, 8, 0, -1, -1, -1);
        n_total++; if (refill_err !== 1'b1) $display("FAIL err_no_rlast: got %b want 1", refill_err); else n_pass++;
        step;
        inst_read_req = 1'b1;
        step;
        n_total++; if (refill_err !== 1'b0) $display("FAIL err_clear2: got %b want 0", refill_err); else n_pass++;
        step;
        inst_read_req = 1'b0;
        beats(32'hD000_0000, 8, 0, -1, -1, 2);
        n_total++; if (refill_err !== 1'b1 || inst_mmu_last !== 1'b1) $display("FAIL err_early_rlast: got %b/%b want 1/1", refill_err, inst_mmu_last); else n_pass++;
        step; step;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; inst_addr_mmu = '0; inst_read_req = 1'b0; arready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        step; step;
        test_reset;
        rst = 1'b0;
        step;
        test_basic;
        test_ar_wait;
        test_gapped_rid;
        test_reset_mid;
        test_back_to_back;
`ifdef ICACHE_REFILL_ERR_EN
        test_err;
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_refill_axi.md
Name: icache_refill_axi

Overview:
AXI read-burst engine directly downstream of the instruction cache's miss port.
- On a line-fill request it issues one INCR burst for the whole cache line on the AXI AR channel.
- It returns the beats to the cache in order, with per-beat valid and last strobes.
- Its AR/R outputs feed the top-level AXI read arbiter alongside the uncached CPU AXI bridge.

Parameters:
LINE_WORDS, 8, 32-bit words per cache line; power of two, 2..16
AXI_ID, 4'd0, value driven on arid; R beats with other rid are ignored

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
inst_addr_mmu  in  32  physical miss address from I$ (any byte in the line)
inst_read_req  in  1  line-fill request, level, held by I$ until inst_addr_ok
inst_addr_ok  out  1  one-cycle pulse: AR handshake done, request accepted
inst_read_data  out  32  returned word
inst_mmu_valid  out  1  inst_read_data valid this cycle
inst_mmu_last  out  1  final word of line, coincident with inst_mmu_valid
arid  out  4  constant AXI_ID
araddr  out  32  line-aligned address
arlen  out  8  constant LINE_WORDS-1
arsize  out  3  constant 3'b010
arburst  out  2  constant 2'b01 (INCR)
arlock  out  2  constant 0
arcache  out  4  constant 0
arprot  out  3  constant 0
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  R id
rdata  in  32  R data
rresp  in  2  R response
rlast  in  1  R last
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Reset (async, rst=1): state=IDLE, beat_cnt=0, araddr=0. All strobes (arvalid, rready, inst_addr_ok, inst_mmu_valid, inst_mmu_last) are 0, and inst_read_data=0.
- State machine:
  - IDLE:
    - If inst_read_req=1: latch araddr = {inst_addr_mmu[31:2+log2(LINE_WORDS)], zeros}.
    - Next cycle, arvalid=1 and go to ADDR.
  - ADDR:
    - arvalid and araddr are held stable until arready=1; AXI rules, no retraction.
    - On the handshake cycle, inst_addr_ok=1 for exactly one cycle (registered, the cycle after the handshake), arvalid drops, beat_cnt=0, go to DATA.
  - DATA:
    - rready=1.
    - An accepted beat is rvalid & rid==AXI_ID.
    - For each accepted beat, the next cycle drives inst_read_data=rdata and inst_mmu_valid=1; beat_cnt increments.
    - inst_mmu_last=1 on the beat where beat_cnt==LINE_WORDS-1.
    - That beat returns the FSM to IDLE; rready=0 from the following cycle.
    - Beats with a mismatched rid are not consumed into the line: rready stays 1 and no output is generated.
- Latency:
  - Request to arvalid: 1 cycle.
  - R beat to inst_mmu_valid: 1 cycle.
  - Back-to-back fills: minimum 1 IDLE cycle between a last beat and the next arvalid.
- Line termination: beat_cnt is authoritative; rlast is not used to end the line.
  - rlast early: beats continue to be accepted until the count completes.
  - rlast missing on the final counted beat: the FSM still returns to IDLE.
- inst_read_req while in ADDR/DATA is ignored; it is re-sampled in IDLE.
  - inst_addr_mmu changes after acceptance have no effect.
- rresp is ignored in the base build.
- Reset mid-burst: everything returns to IDLE immediately. Any outstanding AXI beats arriving after reset release are dropped, because rready=0 in IDLE.
- Only one outstanding burst at a time.

Optional Feature:
Macro ICACHE_REFILL_ERR_EN.
- Defined:
  - Adds output refill_err (1 bit), reset 0.
  - refill_err is set sticky when any accepted beat has rresp!=2'b00, or when rlast disagrees with the count (rlast on a non-final beat, or missing on the final beat).
  - refill_err clears only when a new request is accepted in IDLE.
- Undefined: the port is absent and rresp/rlast are unused.

Test Plan:
- Miss at 0x0000_1234, LINE_WORDS=8, arready same cycle -> araddr=0x0000_1220, arlen=7, arburst=01, one inst_addr_ok pulse, 8 inst_mmu_valid pulses in order, inst_mmu_last only on the 8th.
- arready held low for 5 cycles -> arvalid stays 1 with araddr stable; inst_addr_ok pulses once, after the handshake only.
- rvalid gapped (1 beat every 3 cycles) plus one beat with rid=4'd3 -> the rid=3 beat is not forwarded; exactly 8 valid outputs; last on the 8th accepted beat.
- rst asserted mid-DATA after beat 4, then a new miss at 0x80 -> outputs are 0 during reset; the new burst has araddr=0x80 and delivers 8 fresh beats.
- inst_read_req toggled during DATA -> no second AR until IDLE; the next AR appears 1 cycle after the IDLE re-sample.
- ICACHE_REFILL_ERR_EN defined, beat 3 rresp=2'b10 -> refill_err=1 after that beat, held through the line end, cleared on the next accepted request.
